// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: link between the PC sequencer and the hardware
// return-address stack that sits downstream of it.
//   push       sequencer -> stack  write strobe, captured at the next edge
//   pop        sequencer -> stack  read/discard strobe, captured at the next edge
//   push_data  sequencer -> stack  word to store when push is high
//   stack_top  stack -> sequencer  current top-of-stack word, valid while depth>0
// Modports: master = sequencer side, slave = stack side.
interface pc_sequencer_if #(
  parameter int WIDTH = 10
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] stack_top;

  modport master (
    output push,
    output pop,
    output push_data,
    input  stack_top
  );

  modport slave (
    input  push,
    input  pop,
    input  push_data,
    output stack_top
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencing stage of the 8-bit CPU.
// Holds the PC and picks the next address from the decoded control strobes,
// the zero flag and one level-sensitive interrupt request. It drives the
// return-address stack through the stk interface and tracks the stack
// occupancy itself, so overflow and underflow are caught before the stack
// is written or read out of range.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   jump, jz, jnz        unconditional / zero / not-zero jump to target
//   call, ret, reti      subroutine call, return, return-from-interrupt
//   ei, di               interrupt enable / disable
//   irq                  interrupt request (synchronous to clk)
//   zero                 ALU zero flag
//   target               jump/call destination
//   pc                   current program counter (registered)
//   irq_ack              high in the cycle an interrupt is taken
//   in_isr               high while the interrupt handler runs (registered)
//   depth                stack occupancy 0..DEPTH (registered)
//   ovf, unf             sticky overflow / underflow flags
//   stk                  push/pop/push_data out, stack_top in
module pc_sequencer #(
  parameter int               WIDTH  = 10,
  parameter int               DEPTH  = 8,
  parameter logic [WIDTH-1:0] VECTOR = WIDTH'(10'h3F0)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jump,
  input  logic             jz,
  input  logic             jnz,
  input  logic             call,
  input  logic             ret,
  input  logic             reti,
  input  logic             ei,
  input  logic             di,
  input  logic             irq,
  input  logic             zero,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             irq_ack,
  output logic             in_isr,
  output logic [3:0]       depth,
  output logic             ovf,
  output logic             unf,
  pc_sequencer_if.master   stk
);

  localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

  typedef enum logic [1:0] {
    MASKED  = 2'd0,
    ENABLED = 2'd1,
    IN_ISR  = 2'd2
  } irq_state_t;

  irq_state_t       state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next, pc_inc;
  logic [3:0]       depth_reg, depth_next;
  logic             in_isr_reg;
  logic             ovf_reg, unf_reg;

  logic stack_full, stack_empty;
  logic take_irq, do_ret, do_call, do_branch;
  logic push_en, pop_en;

  // Decode in strict priority order: interrupt entry, ret/reti, call, then
  // any taken jump. Each lower level is masked by everything above it, so
  // exactly one of them (or plain increment) steers the PC.
  always_comb begin
    pc_inc      = pc_reg + WIDTH'(1);
    stack_full  = (depth_reg == DEPTH_MAX);
    stack_empty = (depth_reg == 4'd0);

    // A full stack defers the interrupt rather than flagging it: irq is a
    // level, so it is taken as soon as a slot frees up.
    take_irq  = !reset && (state_reg == ENABLED) && irq && !stack_full;
    do_ret    = !reset && !take_irq && (ret || reti);
    do_call   = !reset && !take_irq && !do_ret && call;
    do_branch = !reset && !take_irq && !do_ret && !do_call &&
                (jump || (jz && zero) || (jnz && !zero));

    push_en = take_irq || (do_call && !stack_full);
    pop_en  = do_ret && !stack_empty;

    // Interrupt entry saves the current PC (the interrupted instruction is
    // discarded and re-executes after reti); a call saves the next one.
    if (take_irq) begin
      pc_next = VECTOR;
    end else if (do_ret) begin
      pc_next = stack_empty ? pc_inc : stk.stack_top;
    end else if (do_call || do_branch) begin
      pc_next = target;
    end else begin
      pc_next = pc_inc;
    end

    depth_next = depth_reg;
    if (push_en) begin
      depth_next = depth_reg + 4'd1;
    end else if (pop_en) begin
      depth_next = depth_reg - 4'd1;
    end

    // ei/di are ignored inside the handler; reti leaves it even when the
    // stack underflowed.
    state_next = state_reg;
    if (take_irq) begin
      state_next = IN_ISR;
    end else begin
      case (state_reg)
        MASKED:  if (ei)   state_next = ENABLED;
        ENABLED: if (di)   state_next = MASKED;
        IN_ISR:  if (reti) state_next = ENABLED;
        default:           state_next = MASKED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= MASKED;
      in_isr_reg <= 1'b0;
      pc_reg     <= '0;
      depth_reg  <= 4'd0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      in_isr_reg <= (state_next == IN_ISR);
      pc_reg     <= pc_next;
      depth_reg  <= depth_next;
      ovf_reg    <= ovf_reg || (do_call && stack_full);
      unf_reg    <= unf_reg || (do_ret && stack_empty);
    end
  end

  assign stk.push      = push_en;
  assign stk.pop       = pop_en;
  assign stk.push_data = take_irq ? pc_reg : pc_inc;

  assign pc      = pc_reg;
  assign irq_ack = take_irq;
  assign in_isr  = in_isr_reg;
  assign depth   = depth_reg;
  assign ovf     = ovf_reg;
  assign unf     = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. The stimulus process
// drives one instruction per cycle, runs a behavioural model (a queue as the
// return stack, two flags for interrupt mode) and pushes the expected
// observation for that cycle; the monitor pops and compares on the falling
// edge. Directed sequences cover the boundary cases, then random traffic.
module tb_pc_sequencer;

  localparam int WIDTH  = 10;
  localparam int DEPTH  = 8;
  localparam int VECTOR = 'h3F0;
  localparam int PCMOD  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             jump, jz, jnz, call, ret, reti, ei, di, irq, zero;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic             irq_ack, in_isr, ovf, unf;
  logic [3:0]       depth;

  pc_sequencer_if #(.WIDTH(WIDTH)) sif ();

  pc_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .VECTOR(10'h3F0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .jump   (jump),
    .jz     (jz),
    .jnz    (jnz),
    .call   (call),
    .ret    (ret),
    .reti   (reti),
    .ei     (ei),
    .di     (di),
    .irq    (irq),
    .zero   (zero),
    .target (target),
    .pc     (pc),
    .irq_ack(irq_ack),
    .in_isr (in_isr),
    .depth  (depth),
    .ovf    (ovf),
    .unf    (unf),
    .stk    (sif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit jump, jz, jnz, call, ret, reti, ei, di, irq, zero;
    int target;
  } ctrl_t;

  typedef struct {
    string tag;
    int    pc, depth, pd;
    bit    isr, ovf, unf, push, pop, ack;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Reference model state.
  int m_pc;
  int m_stk[$];
  bit m_ie, m_isr, m_ovf, m_unf;

  bit irq_lvl  = 1'b0;
  bit zero_lvl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic ctrl_t idle_c();
    ctrl_t c;
    c = '{default: 0};
    c.irq  = irq_lvl;
    c.zero = zero_lvl;
    return c;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ie = 0; m_isr = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Apply one cycle of controls, predict the cycle, advance the model.
  task automatic step(input ctrl_t c, input string tag);
    exp_t e;
    bit   taken;
    jump = c.jump; jz = c.jz; jnz = c.jnz; call = c.call;
    ret = c.ret; reti = c.reti; ei = c.ei; di = c.di;
    irq = c.irq; zero = c.zero; target = WIDTH'(c.target);
    sif.stack_top = (m_stk.size() > 0) ? WIDTH'(m_stk[$]) : WIDTH'($urandom_range(0, PCMOD - 1));

    e = '{tag: tag, pc: m_pc, depth: m_stk.size(), pd: 0, isr: m_isr,
          ovf: m_ovf, unf: m_unf, push: 0, pop: 0, ack: 0};

    taken = m_ie && !m_isr && c.irq && (m_stk.size() < DEPTH);
    if (taken) begin
      e.ack = 1; e.push = 1; e.pd = m_pc;
      m_stk.push_back(m_pc);
      m_pc  = VECTOR;
      m_isr = 1;
    end else begin
      if (!m_isr) begin
        if (!m_ie) m_ie = c.ei;
        else if (c.di) m_ie = 0;
      end
      if (c.ret || c.reti) begin
        if (c.reti && m_isr) begin
          m_isr = 0;
          m_ie  = 1;
        end
        if (m_stk.size() > 0) begin
          e.pop = 1;
          m_pc  = m_stk.pop_back();
        end else begin
          m_unf = 1;
          m_pc  = (m_pc + 1) % PCMOD;
        end
      end else if (c.call) begin
        if (m_stk.size() < DEPTH) begin
          e.push = 1;
          e.pd   = (m_pc + 1) % PCMOD;
          m_stk.push_back(e.pd);
        end else begin
          m_ovf = 1;
        end
        m_pc = c.target;
      end else if (c.jump || (c.jz && c.zero) || (c.jnz && !c.zero)) begin
        m_pc = c.target;
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step(idle_c(), "idle");
  endtask

  task automatic do_call(input int t);
    ctrl_t c = idle_c();
    c.call = 1; c.target = t;
    step(c, "call");
  endtask

  task automatic do_ret(input bit is_reti);
    ctrl_t c = idle_c();
    if (is_reti) c.reti = 1; else c.ret = 1;
    step(c, is_reti ? "reti" : "ret");
  endtask

  task automatic do_jump(input int t);
    ctrl_t c = idle_c();
    c.jump = 1; c.target = t;
    step(c, "jump");
  endtask

  // Monitor: one comparison set per predicted cycle, on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d %s pc=%0h depth=%0d push=%0b pop=%0b ack=%0b isr=%0b",
                 txn, e.tag, pc, depth, sif.push, sif.pop, irq_ack, in_isr);
        chk({e.tag, " pc"},      32'(pc),       32'(e.pc));
        chk({e.tag, " depth"},   32'(depth),    32'(e.depth));
        chk({e.tag, " in_isr"},  32'(in_isr),   32'(e.isr));
        chk({e.tag, " ovf"},     32'(ovf),      32'(e.ovf));
        chk({e.tag, " unf"},     32'(unf),      32'(e.unf));
        chk({e.tag, " push"},    32'(sif.push), 32'(e.push));
        chk({e.tag, " pop"},     32'(sif.pop),  32'(e.pop));
        chk({e.tag, " irq_ack"}, 32'(irq_ack),  32'(e.ack));
        if (e.push) chk({e.tag, " push_data"}, 32'(sif.push_data), 32'(e.pd));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctrl_t c;
    // Reset with noisy controls: strobes must stay low while reset is high.
    jump = 0; jz = 0; jnz = 0; call = 1; ret = 1; reti = 0; ei = 1; di = 0;
    irq = 1; zero = 0; target = '0; sif.stack_top = 10'h155;
    reset = 0;
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("reset pc",      32'(pc),       0);
    chk("reset depth",   32'(depth),    0);
    chk("reset in_isr",  32'(in_isr),   0);
    chk("reset ovf",     32'(ovf),      0);
    chk("reset unf",     32'(unf),      0);
    chk("reset push",    32'(sif.push), 0);
    chk("reset pop",     32'(sif.pop),  0);
    chk("reset irq_ack", 32'(irq_ack),  0);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();

    // Idle count, then call/ret at pc=5.
    do_idle(5);
    do_call('h40);
    do_ret(0);

    // Conditional jumps with zero set.
    zero_lvl = 1;
    c = idle_c(); c.jz = 1;  c.target = 'h10; step(c, "jz");
    c = idle_c(); c.jnz = 1; c.target = 'h55; step(c, "jnz");
    zero_lvl = 0;

    // PC wrap and call from the last address.
    do_jump(1023);
    do_idle(1);
    do_jump(1023);
    do_call('h100);
    do_ret(0);

    // Overflow on the ninth call, then underflow.
    for (int i = 0; i < DEPTH; i++) do_call('h100 + i);
    do_call('h20);
    for (int i = 0; i < DEPTH; i++) do_ret(0);
    do_ret(0);

    // Interrupt taken over a call, no re-entry while held, reti back.
    c = idle_c(); c.ei = 1; step(c, "ei");
    do_jump('h12);
    irq_lvl = 1;
    do_call('h77);
    do_idle(3);
    do_ret(1);
    irq_lvl = 0;

    // Masked irq ignored; full stack defers until a ret frees a slot.
    c = idle_c(); c.di = 1; step(c, "di");
    irq_lvl = 1;
    do_idle(2);
    irq_lvl = 0;
    for (int i = 0; i < DEPTH; i++) do_call('h200 + i);
    irq_lvl = 1;
    c = idle_c(); c.ei = 1; step(c, "ei");
    do_idle(2);
    do_ret(0);
    do_idle(1);
    irq_lvl = 0;
    do_ret(1);
    while (m_stk.size() > 0) do_ret(0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      c.jump   = ($urandom_range(0, 99) < 8);
      c.jz     = ($urandom_range(0, 99) < 8);
      c.jnz    = ($urandom_range(0, 99) < 8);
      c.call   = ($urandom_range(0, 99) < 12);
      c.ret    = ($urandom_range(0, 99) < 10);
      c.reti   = ($urandom_range(0, 99) < 5);
      c.ei     = ($urandom_range(0, 99) < 10);
      c.di     = ($urandom_range(0, 99) < 5);
      c.irq    = ($urandom_range(0, 99) < 30);
      c.zero   = $urandom_range(0, 1);
      c.target = $urandom_range(0, PCMOD - 1);
      step(c, "rand");
    end

    // Asynchronous reset between edges, with strobes requested.
    jump = 0; jz = 0; jnz = 0; call = 1; ret = 1; reti = 1; ei = 0; di = 0; irq = 1;
    if (pc == 0) begin
      do_jump('h2AB);
    end
    #1 reset = 1;
    #1;
    chk("async reset pc",     32'(pc),       0);
    chk("async reset depth",  32'(depth),    0);
    chk("async reset in_isr", 32'(in_isr),   0);
    chk("async reset ovf",    32'(ovf),      0);
    chk("async reset unf",    32'(unf),      0);
    chk("async reset push",   32'(sif.push), 0);
    chk("async reset pop",    32'(sif.pop),  0);
    chk("async reset ack",    32'(irq_ack),  0);
    @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
